// File: rtl/lv_ow_req_arb_pkg.sv
// lv_ow_req_arb_pkg: shared constants and types for the LV one-wire request
// arbiter.
//   - FSM state type (OW_ARB_ST_W bits wide)
//   - requester index constants (FSM ADC, SPI bridge, OW watchdog)
//   - OW payload widths and the default ack timeout
package lv_ow_req_arb_pkg;

  localparam int OW_ARB_ST_W = 2;

  typedef enum logic [OW_ARB_ST_W-1:0] {
    OW_ARB_IDLE     = 2'd0,
    OW_ARB_ISSUE    = 2'd1,
    OW_ARB_WAIT_ACK = 2'd2,
    OW_ARB_RESP     = 2'd3
  } ow_arb_st_e;

  localparam int OW_SRC_FSM = 0;
  localparam int OW_SRC_SPI = 1;
  localparam int OW_SRC_WDG = 2;

  localparam int OW_N_REQ           = 3;
  localparam int OW_SRC_W           = 2;
  localparam int OW_ADDR_W          = 7;
  localparam int OW_DATA_W          = 8;
  localparam int OW_ARB_TIMEOUT_CYC = 512;

endpackage

// File: rtl/lv_rr_pick.sv
// lv_rr_pick: combinational round-robin selector.
// Picks the first asserted request at or after i_ptr, wrapping modulo N_REQ.
// Ports:
//   i_req      request vector
//   i_ptr      priority pointer (must be < N_REQ)
//   o_gnt      one-hot grant (all zero when no request)
//   o_gnt_idx  index of the granted requester (0 when no request)
module lv_rr_pick #(
  parameter int N_REQ = 3,
  parameter int SRC_W = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [SRC_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [SRC_W-1:0] o_gnt_idx
);

  logic found;

  // Outer loop walks priority order starting at the pointer; the inner loop
  // keeps every bit select at a constant index.
  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (!found && i_req[j] && (j == ((int'(i_ptr) + i) % N_REQ))) begin
          found     = 1'b1;
          o_gnt[j]  = 1'b1;
          o_gnt_idx = SRC_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/lv_ow_req_arb.sv
// lv_ow_req_arb: shares the LV one-wire controller between the ctrl FSM,
// the SPI register bridge and the OW watchdog.
// One transaction at a time, round-robin grant, ack timeout.
// Ports:
//   i_clk, i_rst_n                     clock, async active-low reset
//   i_ow_comm_ctrl                     0 blocks new grants
//   i_req/i_req_wr/i_req_addr/i_req_wdata   per-requester request + payload
//   o_ack/o_ack_status/o_rdata         one-cycle completion to the owner
//   o_ow_req/o_ow_wr/o_ow_addr/o_ow_wdata/o_ow_src   to the OW controller
//   i_ow_ack/i_ow_ack_status/i_ow_rdata             from the OW controller
//   o_timeout_err                      pulse with the ack of a timed-out txn
//   o_busy                             high whenever not IDLE
module lv_ow_req_arb
  import lv_ow_req_arb_pkg::*;
#(
  parameter int N_REQ       = OW_N_REQ,
  parameter int SRC_W       = OW_SRC_W,
  parameter int ADDR_W      = OW_ADDR_W,
  parameter int DATA_W      = OW_DATA_W,
  parameter int TIMEOUT_CYC = OW_ARB_TIMEOUT_CYC,
  parameter int TO_CNT_W    = $clog2(TIMEOUT_CYC)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_ow_comm_ctrl,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ-1:0]         i_req_wr,
  input  logic [N_REQ*ADDR_W-1:0]  i_req_addr,
  input  logic [N_REQ*DATA_W-1:0]  i_req_wdata,
  output logic [N_REQ-1:0]         o_ack,
  output logic                     o_ack_status,
  output logic [DATA_W-1:0]        o_rdata,
  output logic                     o_ow_req,
  output logic                     o_ow_wr,
  output logic [ADDR_W-1:0]        o_ow_addr,
  output logic [DATA_W-1:0]        o_ow_wdata,
  output logic [SRC_W-1:0]         o_ow_src,
  input  logic                     i_ow_ack,
  input  logic                     i_ow_ack_status,
  input  logic [DATA_W-1:0]        i_ow_rdata,
  output logic                     o_timeout_err,
  output logic                     o_busy
);

  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYC - 1);

  function automatic logic [SRC_W-1:0] ptr_after(input logic [SRC_W-1:0] idx);
    return (idx == SRC_W'(N_REQ - 1)) ? '0 : idx + SRC_W'(1);
  endfunction

  ow_arb_st_e          state_q, state_d;
  logic [TO_CNT_W-1:0] cnt_q, cnt_d;
  logic [SRC_W-1:0]    ptr_q, ptr_d;
  logic [SRC_W-1:0]    src_q, src_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                status_q, status_d;
  logic                to_q, to_d;

  logic [N_REQ-1:0]    pick_gnt;
  logic [SRC_W-1:0]    pick_idx;
  logic                sel_wr;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  lv_rr_pick #(
    .N_REQ (N_REQ),
    .SRC_W (SRC_W)
  ) u_pick (
    .i_req     (i_req),
    .i_ptr     (ptr_q),
    .o_gnt     (pick_gnt),
    .o_gnt_idx (pick_idx)
  );

  // Payload of the requester the selector currently favours.
  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (pick_gnt[k]) begin
        sel_wr    = i_req_wr[k];
        sel_addr  = i_req_addr[k*ADDR_W +: ADDR_W];
        sel_wdata = i_req_wdata[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    src_d    = src_q;
    gnt_d    = gnt_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    status_d = status_q;
    to_d     = 1'b0;
    unique case (state_q)
      OW_ARB_IDLE: begin
        if ((|i_req) && i_ow_comm_ctrl) begin
          state_d = OW_ARB_ISSUE;
          src_d   = pick_idx;
          gnt_d   = pick_gnt;
          wr_d    = sel_wr;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
        end
      end
      OW_ARB_ISSUE: begin
        cnt_d   = '0;
        state_d = OW_ARB_WAIT_ACK;
      end
      OW_ARB_WAIT_ACK: begin
        cnt_d = cnt_q + TO_CNT_W'(1);
        // A real ack beats the terminal count landing in the same cycle.
        if (i_ow_ack) begin
          rdata_d  = i_ow_rdata;
          status_d = i_ow_ack_status;
          state_d  = OW_ARB_RESP;
        end else if (cnt_q == TO_LAST) begin
          rdata_d  = '0;
          status_d = 1'b1;
          to_d     = 1'b1;
          state_d  = OW_ARB_RESP;
        end
      end
      OW_ARB_RESP: begin
        ptr_d   = ptr_after(src_q);
        state_d = OW_ARB_IDLE;
      end
      default: state_d = OW_ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= OW_ARB_IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      src_q    <= '0;
      gnt_q    <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      status_q <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      src_q    <= src_d;
      gnt_q    <= gnt_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      status_q <= status_d;
      to_q     <= to_d;
    end
  end

  // Response outputs are gated by RESP so they read zero outside the ack
  // cycle even though the capture registers keep their contents.
  assign o_ack         = (state_q == OW_ARB_RESP) ? gnt_q : '0;
  assign o_ack_status  = (state_q == OW_ARB_RESP) & status_q;
  assign o_rdata       = (state_q == OW_ARB_RESP) ? rdata_q : '0;
  assign o_timeout_err = to_q;
  assign o_ow_req      = (state_q == OW_ARB_ISSUE);
  assign o_ow_wr       = wr_q;
  assign o_ow_addr     = addr_q;
  assign o_ow_wdata    = wdata_q;
  assign o_ow_src      = src_q;
  assign o_busy        = (state_q != OW_ARB_IDLE);

endmodule

// File: tb/tb_lv_ow_req_arb.sv
// tb_lv_ow_req_arb: randomized bench for lv_ow_req_arb with a
// transaction-level reference model (round-robin over pending requests,
// ack/timeout timing relative to the issue pulse).
module tb_lv_ow_req_arb;
  import lv_ow_req_arb_pkg::*;

  localparam int N  = 3;
  localparam int SW = 2;
  localparam int AW = 7;
  localparam int DW = 8;
  localparam int TO = 512;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            ctrl = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    req_wr = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    ack;
  logic            ack_status;
  logic [DW-1:0]   rdata;
  logic            ow_req, ow_wr;
  logic [AW-1:0]   ow_addr;
  logic [DW-1:0]   ow_wdata;
  logic [SW-1:0]   ow_src;
  logic            ow_ack = 1'b0;
  logic            ow_ack_status = 1'b0;
  logic [DW-1:0]   ow_rdata = '0;
  logic            to_err, busy;

  always #5 clk = ~clk;

  lv_ow_req_arb #(
    .N_REQ(N), .SRC_W(SW), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ow_comm_ctrl(ctrl),
    .i_req(req), .i_req_wr(req_wr), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_ack(ack), .o_ack_status(ack_status), .o_rdata(rdata),
    .o_ow_req(ow_req), .o_ow_wr(ow_wr), .o_ow_addr(ow_addr), .o_ow_wdata(ow_wdata),
    .o_ow_src(ow_src), .i_ow_ack(ow_ack), .i_ow_ack_status(ow_ack_status),
    .i_ow_rdata(ow_rdata), .o_timeout_err(to_err), .o_busy(busy)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  // reference model state
  bit           open_m = 0;
  int           gnt_m = 0;
  int           ptr_m = 0;
  int           t_issue = -10;
  int           exp_ack_cyc = -10;
  bit           exp_to = 0;
  bit           exp_st = 0;
  bit [DW-1:0]  exp_rd = '0;
  int           ack_at = -1;
  bit [DW-1:0]  rsp_rd = '0;
  bit           rsp_st = 0;
  bit [N-1:0]   req_prev = '0;
  bit           ctrl_prev = 0;
  bit           idle_prev = 1;
  bit [SW-1:0]  exp_src = '0;
  bit           exp_wr = 0;
  bit [AW-1:0]  exp_addr = '0;
  bit [DW-1:0]  exp_wdata = '0;

  // stimulus knobs
  int           k_mode = 1;     // 0 random, 1 immediate, 2 no ack, 3 tie, 4 fixed delay
  bit           k_tie_st = 0;
  int           k_d = 5;
  bit [DW-1:0]  k_rd = '0;
  bit [N-1:0]   k_mask = '0;
  bit           k_hold_all = 0;
  int           k_req_pct = 0;
  bit           k_ctrl_rand = 0;
  bit           k_spur = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_chk++;
    if (obs === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, want, cyc);
  endtask

  function automatic logic [63:0] outs_vec();
    return {31'd0, ack, ack_status, rdata, ow_req, ow_wr, ow_addr, ow_wdata, ow_src, to_err, busy};
  endfunction

  // first pending requester at or after the pointer, wrapping
  function automatic int rr_ref(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return 0;
  endfunction

  task automatic cycle_step();
    bit           want_req;
    bit [N-1:0]   want_ack;
    bit           ack_cyc;
    int           w, d, r, drop_k;
    @(negedge clk);
    cyc++;
    req_prev  = req;
    ctrl_prev = ctrl;

    want_req = idle_prev && ctrl_prev && (req_prev != '0);
    check_val("ow_req", ow_req, want_req);
    if (want_req) begin
      w         = rr_ref(req_prev, ptr_m);
      open_m    = 1;
      gnt_m     = w;
      t_issue   = cyc;
      exp_src   = SW'(w);
      exp_wr    = req_wr[w];
      exp_addr  = req_addr[w*AW +: AW];
      exp_wdata = req_wdata[w*DW +: DW];
      rsp_rd    = DW'($urandom);
      rsp_st    = 1'($urandom);
      case (k_mode)
        0: begin
          r = $urandom_range(0, 19);
          d = (r < 18) ? $urandom_range(1, 8) : ((r == 18) ? TO : TO + 1);
        end
        1: d = 1;
        2: d = TO + 1;
        3: begin d = TO; rsp_st = k_tie_st; end
        default: begin d = k_d; rsp_rd = k_rd; rsp_st = 0; end
      endcase
      ack_at = cyc + d;
      if (d <= TO) begin
        exp_ack_cyc = cyc + d + 1; exp_to = 0; exp_st = rsp_st; exp_rd = rsp_rd;
      end else begin
        exp_ack_cyc = cyc + TO + 1; exp_to = 1; exp_st = 1; exp_rd = '0;
      end
    end

    ack_cyc  = open_m && (cyc == exp_ack_cyc);
    want_ack = ack_cyc ? N'(1 << gnt_m) : '0;
    check_val("ack", ack, want_ack);
    check_val("ack_status", ack_status, ack_cyc ? exp_st : 1'b0);
    check_val("rdata", rdata, ack_cyc ? exp_rd : '0);
    check_val("timeout_err", to_err, ack_cyc && exp_to);
    check_val("busy", busy, open_m);
    check_val("ow_src", ow_src, exp_src);
    check_val("ow_wr", ow_wr, exp_wr);
    check_val("ow_addr", ow_addr, exp_addr);
    check_val("ow_wdata", ow_wdata, exp_wdata);

    idle_prev = !open_m;
    drop_k = -1;
    if (ack_cyc) begin
      open_m = 0;
      ptr_m  = (gnt_m + 1) % N;
      drop_k = gnt_m;
      req[gnt_m] = 1'b0;
    end

    // requesters
    for (int k = 0; k < N; k++) begin
      if (!req[k] && k != drop_k && k_mask[k] &&
          (k_hold_all || $urandom_range(0, 99) < k_req_pct)) begin
        req[k]                  = 1'b1;
        req_wr[k]               = 1'($urandom);
        req_addr[k*AW +: AW]    = AW'($urandom);
        req_wdata[k*DW +: DW]   = DW'($urandom);
      end
    end
    if (k_ctrl_rand && $urandom_range(0, 49) == 0) ctrl = ~ctrl;

    // OW controller side
    ow_rdata      = DW'($urandom);
    ow_ack_status = 1'($urandom);
    ow_ack        = 1'b0;
    if (cyc == ack_at) begin
      ow_ack = 1'b1; ow_rdata = rsp_rd; ow_ack_status = rsp_st;
    end else if ((!open_m || cyc == t_issue) && k_spur && $urandom_range(0, 9) == 0) begin
      ow_ack = 1'b1;
    end
  endtask

  task automatic reset_mid();
    int n = 0;
    do begin
      cycle_step();
      n++;
    end while (!(open_m && cyc > t_issue && cyc < exp_ack_cyc) && n < 200);
    check_val("reach_wait", open_m && cyc > t_issue && cyc < exp_ack_cyc, 1);
    #2 rst_n = 1'b0;
    #1 check_val("rst_mid_outs", outs_vec(), '0);
    open_m = 0; ptr_m = 0; ack_at = -1; ow_ack = 1'b0; idle_prev = 1;
    exp_src = '0; exp_wr = 0; exp_addr = '0; exp_wdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 check_val("rst_outs", outs_vec(), '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // single FSM read, ack 5 cycles after issue with 0xA5
    ctrl = 1'b1;
    req[0] = 1'b1; req_wr[0] = 1'b0; req_addr[0 +: AW] = 7'h12;
    k_mode = 4; k_d = 5; k_rd = 8'hA5;
    repeat (15) cycle_step();

    // all three requesting, immediate acks
    k_mode = 1; k_mask = 3'b111; k_hold_all = 1;
    repeat (30) cycle_step();
    k_mask = '0; k_hold_all = 0;
    repeat (10) cycle_step();

    // SPI write with no ack, late ack lands on the response cycle
    req[1] = 1'b1; req_wr[1] = 1'b1; req_addr[AW +: AW] = 7'h35; req_wdata[DW +: DW] = 8'h5C;
    k_mode = 2;
    repeat (525) cycle_step();

    // ack coincides with the terminal count, status 1 then 0
    k_mode = 3; k_tie_st = 1; req[0] = 1'b1;
    repeat (525) cycle_step();
    k_tie_st = 0; req[2] = 1'b1;
    repeat (525) cycle_step();

    // grants gated by i_ow_comm_ctrl
    ctrl = 1'b0; req[2] = 1'b1; k_mode = 4; k_d = 5; k_rd = 8'h3C;
    repeat (100) cycle_step();
    ctrl = 1'b1;
    repeat (3) cycle_step();
    ctrl = 1'b0; req[0] = 1'b1;
    repeat (30) cycle_step();
    ctrl = 1'b1;
    repeat (15) cycle_step();

    // reset during WAIT_ACK, then round-robin restarts from requester 0
    k_mask = 3'b111; k_hold_all = 1; k_mode = 4; k_d = 6;
    reset_mid();
    k_mode = 1;
    repeat (30) cycle_step();

    // randomized traffic
    k_hold_all = 0; k_req_pct = 30; k_ctrl_rand = 1; k_spur = 1; k_mode = 0;
    repeat (4000) cycle_step();

    // drain
    k_mask = '0; k_ctrl_rand = 0; k_spur = 0; ctrl = 1'b1; k_mode = 1;
    repeat (600) cycle_step();
    check_val("drain_idle", busy, 1'b0);
    check_val("drain_no_req", req, '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
